// File: rtl/avalon_cmpt_cpu_debug_ocimem_if.sv
// Avalon-MM slave bus of the CPU debug on-chip memory.
interface avalon_cmpt_cpu_debug_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic              chipselect;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output chipselect, read, write, address, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_cmpt_cpu_debug_ocimem.sv
// Debug on-chip RAM shared by JTAG debug commands (priority) and an Avalon-MM slave.
// Define DEBUG_OCIMEM_BYTEENABLE_EN to honour Avalon byte enables on writes.
module avalon_cmpt_cpu_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [37:0]                    jdo,
    input  logic                           take_action_ocimem_a,
    input  logic                           take_no_action_ocimem_a,
    input  logic                           take_action_ocimem_b,
    output logic [31:0]                    MonDReg,
    output logic                           monitor_ready,
    output logic                           monitor_error,
    avalon_cmpt_cpu_debug_ocimem_if.slave  av
);
    typedef enum logic [1:0] {IDLE, J_RD, AV_RD} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_NA, CMD_B} cmd_t;

    state_t            state_q, state_d;
    cmd_t              new_cmd, exec_cmd, pend_cmd_q, pend_cmd_d;
    logic [37:0]       exec_jdo, pend_jdo_q, pend_jdo_d;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_d, mon_a_inc, jdo_addr;
    logic [31:0]       mon_d_d, rd_hold_q, ram_q;
    logic              ready_d, error_d, error_set, error_clr;
    logic              strobe_clash, av_req;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_wbe, av_be;
    logic [31:0]       mem [2**ADDR_W];

`ifdef DEBUG_OCIMEM_BYTEENABLE_EN
    assign av_be = av.byteenable;
`else
    logic unused_be;
    assign unused_be = ^av.byteenable;
    assign av_be     = 4'hF;
`endif

    assign mon_a_inc    = mon_a_reg + 1'b1;
    assign jdo_addr     = exec_jdo[ADDR_W+16:17];
    assign av_req       = av.chipselect & (av.read | av.write);
    assign strobe_clash = (take_action_ocimem_b & take_action_ocimem_a)
                        | (take_action_ocimem_b & take_no_action_ocimem_a)
                        | (take_action_ocimem_a & take_no_action_ocimem_a);

    always_comb begin
        new_cmd = CMD_NONE;
        if (take_action_ocimem_b)         new_cmd = CMD_B;
        else if (take_action_ocimem_a)    new_cmd = CMD_A;
        else if (take_no_action_ocimem_a) new_cmd = CMD_NA;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d        = state_q;
        mon_a_d        = mon_a_reg;
        pend_cmd_d     = pend_cmd_q;
        pend_jdo_d     = pend_jdo_q;
        mon_d_d        = MonDReg;
        ready_d        = monitor_ready;
        error_set      = strobe_clash;
        error_clr      = 1'b0;
        exec_cmd       = CMD_NONE;
        exec_jdo       = jdo;
        ram_we         = 1'b0;
        ram_waddr      = mon_a_reg;
        ram_wdata      = '0;
        ram_wbe        = '0;
        ram_raddr      = mon_a_reg;
        av.waitrequest = av_req;

        case (state_q)
            IDLE: begin
                if (new_cmd != CMD_NONE) begin
                    exec_cmd = new_cmd;
                end else if (pend_cmd_q != CMD_NONE) begin
                    exec_cmd   = pend_cmd_q;
                    exec_jdo   = pend_jdo_q;
                    pend_cmd_d = CMD_NONE;
                end else if (av_req) begin
                    if (av.write) begin
                        ram_we         = 1'b1;
                        ram_waddr      = av.address;
                        ram_wdata      = av.writedata;
                        ram_wbe        = av_be;
                        av.waitrequest = 1'b0;
                    end else begin
                        ram_raddr = av.address;
                        state_d   = AV_RD;
                    end
                end
            end
            J_RD: begin
                mon_d_d = ram_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            AV_RD: begin
                av.waitrequest = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe during a read cycle parks in the single pending slot, or is lost.
        if (state_q != IDLE && new_cmd != CMD_NONE) begin
            if (pend_cmd_q == CMD_NONE) begin
                pend_cmd_d = new_cmd;
                pend_jdo_d = jdo;
            end else begin
                error_set = 1'b1;
            end
        end

        case (exec_cmd)
            CMD_A: begin
                mon_a_d   = jdo_addr;
                error_clr = exec_jdo[35];
                if (exec_jdo[34]) begin
                    ram_raddr = jdo_addr;
                    ready_d   = 1'b0;
                    state_d   = J_RD;
                end
            end
            CMD_NA: begin
                mon_a_d   = mon_a_inc;
                ram_raddr = mon_a_inc;
                ready_d   = 1'b0;
                state_d   = J_RD;
            end
            CMD_B: begin
                ram_we    = 1'b1;
                ram_waddr = mon_a_reg;
                ram_wdata = exec_jdo[34:3];
                ram_wbe   = 4'hF;
                mon_a_d   = mon_a_inc;
            end
            default: ;
        endcase

        error_d = monitor_error;
        if (error_clr) error_d = 1'b0;
        if (error_set) error_d = 1'b1;
    end

    // Hold the last Avalon read result so readdata is stable outside AV_RD.
    assign av.readdata = (state_q == AV_RD) ? ram_q : rd_hold_q;

    // NOTE: the RAM array has no reset; contents survive reset and only control state is cleared.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_wbe[i]) mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mon_a_reg     <= '0;
            pend_cmd_q    <= CMD_NONE;
            pend_jdo_q    <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            rd_hold_q     <= '0;
        end else begin
            state_q       <= state_d;
            mon_a_reg     <= mon_a_d;
            pend_cmd_q    <= pend_cmd_d;
            pend_jdo_q    <= pend_jdo_d;
            MonDReg       <= mon_d_d;
            monitor_ready <= ready_d;
            monitor_error <= error_d;
            if (state_q == AV_RD) rd_hold_q <= ram_q;
        end
    end
endmodule

// File: tb/tb_avalon_cmpt_cpu_debug_ocimem.sv
// Directed self-checking bench for avalon_cmpt_cpu_debug_ocimem (ADDR_W = 8).
module tb_avalon_cmpt_cpu_debug_ocimem;
    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [31:0] mon_d;
    logic        mon_ready, mon_error;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_be;

    avalon_cmpt_cpu_debug_ocimem_if #(.ADDR_W(8)) av ();

    avalon_cmpt_cpu_debug_ocimem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_error),
        .av                      (av.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        jdo_a        = '0;
        jdo_a[24:17] = addr;
        jdo_a[34]    = rd;
        jdo_a[35]    = clr;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        jdo_b       = '0;
        jdo_b[34:3] = data;
    endfunction

    task automatic jtag_idle();
        take_a = 1'b0; take_na = 1'b0; take_b = 1'b0; jdo = '0;
    endtask

    task automatic av_idle();
        av.chipselect = 1'b0; av.read = 1'b0; av.write = 1'b0;
        av.address = '0; av.writedata = '0; av.byteenable = 4'hF;
    endtask

    task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        av.chipselect = 1'b1; av.write = 1'b1; av.read = 1'b0;
        av.address = a; av.writedata = d; av.byteenable = be;
        #1 check("av_wr_nowait", 32'(av.waitrequest), 32'd0);
        tick();
        av_idle();
    endtask

    initial begin
`ifdef DEBUG_OCIMEM_BYTEENABLE_EN
        exp_be = 32'hAABB3344;
`else
        exp_be = 32'h11223344;
`endif
        reset = 1'b1;
        jtag_idle();
        av_idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_mondreg", mon_d, 32'd0);
        check("rst_ready",   32'(mon_ready), 32'd0);
        check("rst_error",   32'(mon_error), 32'd0);
        check("rst_rdata",   av.readdata, 32'd0);
        check("rst_wait",    32'(av.waitrequest), 32'd0);

        // Load address without read.
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b0, 1'b0);
        tick(); jtag_idle();
        check("lda_areg",  32'(dut.mon_a_reg), 32'h10);
        check("lda_ready", 32'(mon_ready), 32'd0);

        // JTAG write then read back with two-cycle latency.
        take_b = 1'b1; jdo = jdo_b(32'hDEADBEEF);
        tick(); jtag_idle();
        check("wr_inc", 32'(dut.mon_a_reg), 32'h11);
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b0);
        tick(); jtag_idle();
        check("rd_n1_ready", 32'(mon_ready), 32'd0);
        tick();
        check("rd_n2_ready", 32'(mon_ready), 32'd1);
        check("rd_n2_data",  mon_d, 32'hDEADBEEF);

        // Address wrap on increment-and-read.
        take_a = 1'b1; jdo = jdo_a(8'h00, 1'b0, 1'b0);
        tick();
        jtag_idle(); take_b = 1'b1; jdo = jdo_b(32'h0BADF00D);
        tick();
        jtag_idle(); take_a = 1'b1; jdo = jdo_a(8'hFF, 1'b0, 1'b0);
        tick();
        jtag_idle(); take_na = 1'b1;
        tick(); jtag_idle();
        tick();
        check("wrap_areg",  32'(dut.mon_a_reg), 32'h00);
        check("wrap_ready", 32'(mon_ready), 32'd1);
        check("wrap_data",  mon_d, 32'h0BADF00D);

        // Avalon writes, byte-enable merge, and read latency.
        av_write(8'h20, 32'hAABBCCDD, 4'hF);
        av_write(8'h20, 32'h11223344, 4'b0011);
        av_write(8'h11, 32'h55AA55AA, 4'hF);
        av.chipselect = 1'b1; av.read = 1'b1; av.address = 8'h20;
        #1 check("avrd_wait_m", 32'(av.waitrequest), 32'd1);
        tick();
        check("avrd_wait_m1", 32'(av.waitrequest), 32'd0);
        check("avrd_be_data", av.readdata, exp_be);
        av_idle();
        tick();
        check("avrd_hold", av.readdata, exp_be);

        // Avalon read contending with a JTAG read strobe.
        av.chipselect = 1'b1; av.read = 1'b1; av.address = 8'h20;
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b0);
        #1 check("cont_wait_n", 32'(av.waitrequest), 32'd1);
        tick(); jtag_idle();
        check("cont_wait_jrd", 32'(av.waitrequest), 32'd1);
        tick();
        check("cont_wait_acc", 32'(av.waitrequest), 32'd1);
        check("cont_jtag_rdy", 32'(mon_ready), 32'd1);
        check("cont_jtag_dat", mon_d, 32'hDEADBEEF);
        tick();
        check("cont_wait_done", 32'(av.waitrequest), 32'd0);
        check("cont_rdata",     av.readdata, exp_be);
        av_idle();
        tick();

        // Read-after-write on consecutive cycles.
        av_write(8'h30, 32'h12345678, 4'hF);
        av.chipselect = 1'b1; av.read = 1'b1; av.address = 8'h30;
        tick();
        check("raw_rdata", av.readdata, 32'h12345678);
        av_idle();
        tick();

        // Pending slot fill, JTAG beating pending, overrun drop.
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b0);
        tick();
        jtag_idle(); take_b = 1'b1; jdo = jdo_b(32'hCAFE0001);
        tick();
        check("pend_ready", 32'(mon_ready), 32'd1);
        check("pend_error", 32'(mon_error), 32'd0);
        jtag_idle(); take_na = 1'b1;
        tick();
        jtag_idle(); take_a = 1'b1; jdo = jdo_a(8'h40, 1'b1, 1'b0);
        tick(); jtag_idle();
        check("drop_error", 32'(mon_error), 32'd1);
        check("drop_data",  mon_d, 32'h55AA55AA);
        tick();
        check("pend_exec_areg", 32'(dut.mon_a_reg), 32'h12);
        take_a = 1'b1; jdo = jdo_a(8'h11, 1'b1, 1'b0);
        tick(); jtag_idle();
        tick();
        check("pend_exec_data", mon_d, 32'hCAFE0001);
        check("err_sticky",     32'(mon_error), 32'd1);
        take_a = 1'b1; jdo = jdo_a(8'h11, 1'b0, 1'b0);
        tick(); jtag_idle();
        check("err_noclr", 32'(mon_error), 32'd1);
        take_a = 1'b1; jdo = jdo_a(8'h11, 1'b0, 1'b1);
        tick(); jtag_idle();
        check("err_clr", 32'(mon_error), 32'd0);

        // Simultaneous strobes: ocimem_b wins, ocimem_a dropped with error.
        take_b = 1'b1; take_a = 1'b1; jdo = jdo_b(32'h77777777);
        tick(); jtag_idle();
        check("clash_error", 32'(mon_error), 32'd1);
        check("clash_areg",  32'(dut.mon_a_reg), 32'h12);
        take_a = 1'b1; jdo = jdo_a(8'h11, 1'b1, 1'b1);
        tick(); jtag_idle();
        tick();
        check("clash_data",  mon_d, 32'h77777777);
        check("clash_clr",   32'(mon_error), 32'd0);

        // Reset in the middle of a JTAG read; RAM contents survive.
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b0);
        tick(); jtag_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_ready", 32'(mon_ready), 32'd0);
        check("mrst_data",  mon_d, 32'd0);
        check("mrst_areg",  32'(dut.mon_a_reg), 32'd0);
        take_a = 1'b1; jdo = jdo_a(8'h10, 1'b1, 1'b0);
        tick(); jtag_idle();
        tick();
        check("mrst_ram", mon_d, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
